// File: rtl/niski_io_pkg.sv
// Shared I/O constants and event record for the Niski button conditioner
// and the GPIO register block that consumes its flags.
package niski_io_pkg;
  localparam int BTN_CHANNELS_DEFAULT      = 5;
  localparam int BTN_STABLE_CYCLES_DEFAULT = 4;
  localparam int BTN_HOLD_CYCLES_DEFAULT   = 16;

  typedef struct packed {
    logic [BTN_CHANNELS_DEFAULT-1:0] pressed;
    logic [BTN_CHANNELS_DEFAULT-1:0] released;
    logic [BTN_CHANNELS_DEFAULT-1:0] held;
  } btn_events_t;
endpackage

// File: rtl/btn_conditioner_if.sv
// Pin, clear/mask and event bundle between the board pins, the conditioner
// and the CPU-side register logic.
interface btn_conditioner_if import niski_io_pkg::*; #(
  parameter int CHANNELS = BTN_CHANNELS_DEFAULT
) ();
  logic [CHANNELS-1:0] btn_pins;
  logic                clr_en;
  logic [CHANNELS-1:0] clr_mask;
  logic [CHANNELS-1:0] irq_mask;
  logic [CHANNELS-1:0] state;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] released;
  logic [CHANNELS-1:0] held;
  logic                irq;

  modport master (
    output btn_pins, clr_en, clr_mask, irq_mask,
    input  state, pressed, released, held, irq
  );

  modport slave (
    input  btn_pins, clr_en, clr_mask, irq_mask,
    output state, pressed, released, held, irq
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce and hold counters, and
// sticky press/release/hold flags. Input is already active-high.
module btn_debounce_ch import niski_io_pkg::*; #(
  parameter int STABLE_CYCLES = BTN_STABLE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES   = BTN_HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  input  logic i_clr,
  output logic o_state,
  output logic o_pressed,
  output logic o_released,
  output logic o_held
);
  localparam int DB_W = $clog2(STABLE_CYCLES + 1);
  localparam int HD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_MAX  = HD_W'(HOLD_CYCLES);

  logic [1:0]      r_sync;
  logic [DB_W-1:0] r_db_cnt;
  logic [HD_W-1:0] r_hold_cnt;
  logic            r_state;
  logic            r_pressed;
  logic            r_released;
  logic            r_held;
  logic            w_toggle;
  logic            w_rise;
  logic            w_fall;
  logic            w_hold_hit;

  assign w_toggle   = (r_sync[1] != r_state) && (r_db_cnt == DB_LAST);
  assign w_rise     = w_toggle & ~r_state;
  assign w_fall     = w_toggle & r_state;
  // Counter parks at HD_MAX, so the hit fires once per press.
  assign w_hold_hit = r_state && (r_hold_cnt == HD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_state    <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};

      if (r_sync[1] == r_state) begin
        r_db_cnt <= '0;
      end else if (w_toggle) begin
        r_db_cnt <= '0;
        r_state  <= ~r_state;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end

      if (!r_state) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != HD_MAX) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end

      // A set on the same edge as a clear wins so no event is lost.
      r_pressed  <= w_rise     | (r_pressed  & ~i_clr);
      r_released <= w_fall     | (r_released & ~i_clr);
      r_held     <= w_hold_hit | (r_held     & ~i_clr);
    end
  end

  assign o_state    = r_state;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;
  assign o_held     = r_held;
endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: polarity fold, per-channel debounce
// with sticky events, and a registered masked interrupt.
module btn_conditioner import niski_io_pkg::*; #(
  parameter int CHANNELS      = BTN_CHANNELS_DEFAULT,
  parameter int STABLE_CYCLES = BTN_STABLE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES   = BTN_HOLD_CYCLES_DEFAULT,
  parameter int ACTIVE_LOW    = 1
) (
  input logic              clk,
  input logic              rst_n,
  btn_conditioner_if.slave bus
);
  logic [CHANNELS-1:0] w_pins;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_state;
  logic [CHANNELS-1:0] w_pressed;
  logic [CHANNELS-1:0] w_released;
  logic [CHANNELS-1:0] w_held;
  logic                r_irq;

  assign w_pins = bus.btn_pins ^ {CHANNELS{ACTIVE_LOW != 0}};
  assign w_clr  = {CHANNELS{bus.clr_en}} & bus.clr_mask;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pin     (w_pins[g]),
      .i_clr     (w_clr[g]),
      .o_state   (w_state[g]),
      .o_pressed (w_pressed[g]),
      .o_released(w_released[g]),
      .o_held    (w_held[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |((w_pressed | w_released | w_held) & bus.irq_mask);
    end
  end

  assign bus.state    = w_state;
  assign bus.pressed  = w_pressed;
  assign bus.released = w_released;
  assign bus.held     = w_held;
  assign bus.irq      = r_irq;
endmodule

// File: tb/tb_btn_conditioner.sv
// Scenario bench for btn_conditioner: expected snapshots of state, flags and
// irq are queued when stimulus is applied and compared when the edge arrives.
module tb_btn_conditioner;
  import niski_io_pkg::*;

  localparam int CH = 5;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  btn_conditioner_if #(.CHANNELS(CH)) bus ();

  btn_conditioner #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(4),
    .HOLD_CYCLES  (16),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [20:0] mk(input logic [4:0] st, input btn_events_t ev,
                                     input logic irq);
    return {st, ev, irq};
  endfunction

  function automatic logic [20:0] snap(input logic [4:0] st_acc);
    btn_events_t ev;
    ev.pressed  = bus.pressed;
    ev.released = bus.released;
    ev.held     = bus.held;
    return {st_acc, ev, bus.irq};
  endfunction

  function automatic btn_events_t evs(input logic [4:0] p, input logic [4:0] r,
                                      input logic [4:0] h);
    btn_events_t e;
    e.pressed  = p;
    e.released = r;
    e.held     = h;
    return e;
  endfunction

  task automatic expect_snap(input string tag, input logic [4:0] st,
                             input logic [4:0] p, input logic [4:0] r,
                             input logic [4:0] h, input logic irq);
    exp_t e;
    e.tag = tag;
    e.v   = mk(st, evs(p, r, h), irq);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.btn_pins = 5'b11111;
    bus.clr_en   = 1'b0;
    bus.clr_mask = 5'b00000;
    bus.irq_mask = 5'b11111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [20:0] o;
    rst_n        = 1'b0;
    bus.btn_pins = 5'b00000;
    bus.clr_en   = 1'b0;
    bus.clr_mask = 5'b00000;
    bus.irq_mask = 5'b11111;
    expect_snap("reset_state", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    tick(3);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
  endtask

  task automatic test_clean_press();
    exp_t e;
    logic [20:0] o;
    do_reset();
    bus.btn_pins[3] = 1'b0;
    expect_snap("press_edge5", 5'b00000, 5'b00000, 5'b0, 5'b0, 1'b0);
    expect_snap("press_edge6", 5'b01000, 5'b01000, 5'b0, 5'b0, 1'b0);
    expect_snap("press_irq7",  5'b01000, 5'b01000, 5'b0, 5'b0, 1'b1);
    tick(5);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic [20:0] o;
    logic [4:0]  st_acc;
    do_reset();
    st_acc = '0;
    expect_snap("bounce_reject", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.btn_pins[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin tick(1); st_acc |= bus.state; end
      bus.btn_pins[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin tick(1); st_acc |= bus.state; end
    end
    for (int k = 0; k < 10; k++) begin tick(1); st_acc |= bus.state; end
    o = snap(st_acc); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
  endtask

  task automatic test_long_hold();
    exp_t e;
    logic [20:0] o;
    do_reset();
    bus.btn_pins[1] = 1'b0;
    expect_snap("hold_rise",     5'b00010, 5'b00010, 5'b0, 5'b00000, 1'b0);
    expect_snap("hold_pre15",    5'b00010, 5'b00010, 5'b0, 5'b00000, 1'b1);
    expect_snap("hold_set16",    5'b00010, 5'b00010, 5'b0, 5'b00010, 1'b1);
    expect_snap("hold_clear",    5'b00010, 5'b00000, 5'b0, 5'b00000, 1'b1);
    expect_snap("hold_once",     5'b00010, 5'b00000, 5'b0, 5'b00000, 1'b0);
    expect_snap("release_pre5",  5'b00010, 5'b00000, 5'b0, 5'b00000, 1'b0);
    expect_snap("release_edge6", 5'b00000, 5'b00000, 5'b00010, 5'b0, 1'b0);
    expect_snap("release_irq",   5'b00000, 5'b00000, 5'b00010, 5'b0, 1'b1);
    tick(6);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(15);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    bus.clr_en   = 1'b1;
    bus.clr_mask = 5'b00010;
    tick(1);
    bus.clr_en = 1'b0;
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(12);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    bus.btn_pins[1] = 1'b1;
    tick(5);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
  endtask

  task automatic test_clear_collision();
    exp_t e;
    logic [20:0] o;
    do_reset();
    bus.btn_pins[2] = 1'b0;
    expect_snap("collide_set_wins", 5'b00100, 5'b00100, 5'b0, 5'b0, 1'b0);
    expect_snap("collide_clear",    5'b00100, 5'b00000, 5'b0, 5'b0, 1'b1);
    expect_snap("collide_irq_drop", 5'b00100, 5'b00000, 5'b0, 5'b0, 1'b0);
    tick(5);
    bus.clr_en   = 1'b1;
    bus.clr_mask = 5'b00100;
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    bus.clr_en = 1'b0;
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
  endtask

  task automatic test_mask_concurrency();
    exp_t e;
    logic [20:0] o;
    do_reset();
    bus.irq_mask = 5'b00001;
    bus.btn_pins = 5'b01110;
    expect_snap("conc_both",      5'b10001, 5'b10001, 5'b0, 5'b0, 1'b0);
    expect_snap("conc_irq",       5'b10001, 5'b10001, 5'b0, 5'b0, 1'b1);
    expect_snap("conc_clear0",    5'b10001, 5'b10000, 5'b0, 5'b0, 1'b1);
    expect_snap("conc_irq_mask4", 5'b10001, 5'b10000, 5'b0, 5'b0, 1'b0);
    tick(6);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    bus.clr_en   = 1'b1;
    bus.clr_mask = 5'b00001;
    tick(1);
    bus.clr_en = 1'b0;
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    bus.irq_mask = 5'b11111;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [20:0] o;
    do_reset();
    bus.btn_pins[0] = 1'b0;
    expect_snap("ar_pre_press", 5'b00001, 5'b00001, 5'b0, 5'b0, 1'b1);
    expect_snap("ar_immediate", 5'b00000, 5'b00000, 5'b0, 5'b0, 1'b0);
    expect_snap("ar_redb_pre5", 5'b00000, 5'b00000, 5'b0, 5'b0, 1'b0);
    expect_snap("ar_redb_6",    5'b00101, 5'b00101, 5'b0, 5'b0, 1'b0);
    tick(7);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    bus.btn_pins[2] = 1'b0;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    #3;
    rst_n = 1'b1;
    tick(5);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
    tick(1);
    o = snap(bus.state); e = exp_q.pop_front(); n_cmp++;
    if (o !== e.v) begin n_err++; $display("FAIL %s: got %b want %b", e.tag, o, e.v); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_clear_collision();
    test_mask_concurrency();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel push-button conditioner for the Niski board: it synchronises raw button pins, debounces each channel independently, and records sticky press, release and long-hold events. It sits between the top-level `BTN_PINS` and the CPU-visible GPIO/interrupt logic, replacing per-button ad-hoc inversion and edge detection. Software reads the debounced state and event flags, then clears flags with a masked write.

## Interface
Parameters:
- `CHANNELS`, 5: number of button channels.
- `STABLE_CYCLES`, 4: consecutive synchronised cycles a new level must hold before it is accepted. Must be ≥ 1.
- `HOLD_CYCLES`, 16: cycles a channel must stay pressed before its `held` flag sets. Must be > 0.
- `ACTIVE_LOW`, 1: 1 means a pin at 0 is "pressed".

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `btn_pins`  in  CHANNELS  raw, asynchronous pin levels.
- `clr_en`  in  1  clear strobe for event flags.
- `clr_mask`  in  CHANNELS  channels whose flags `clr_en` clears.
- `irq_mask`  in  CHANNELS  channels allowed to raise `irq`.
- `state`  out  CHANNELS  debounced level; 1 = pressed.
- `pressed`  out  CHANNELS  sticky press-event flags.
- `released`  out  CHANNELS  sticky release-event flags.
- `held`  out  CHANNELS  sticky long-hold flags.
- `irq`  out  1  registered OR of masked pending events.

## Operation
- **Polarity:** each pin is XORed with `ACTIVE_LOW` before synchronisation, so all logic after that point is active-high.
- **Synchroniser:** two flops per channel. Reset value is logical 0 (not pressed).
- **Debounce, per channel:**
  - The counter resets to 0 whenever the synchronised value equals `state`.
  - Otherwise the counter increments.
  - When the counter reaches `STABLE_CYCLES-1` with the input still differing, `state` toggles on the next edge and the counter resets to 0.
  - Any bounce back to the `state` level restarts the count.
- **Events:**
  - A `state` transition 0→1 sets `pressed`.
  - A `state` transition 1→0 sets `released`.
  - Flags stay set until cleared.
- **Hold:**
  - The hold counter counts cycles while `state`=1 and saturates at `HOLD_CYCLES`.
  - On reaching `HOLD_CYCLES`, `held` sets once per press.
  - The hold counter clears when `state`=0.
- **Clear:** when `clr_en`=1, flags of channels with `clr_mask`=1 clear.
- **Simultaneous set and clear on the same channel and edge:** set wins, so the event is not lost.
- **irq:** registered `|((pressed|released|held) & irq_mask)`.
- **Counter widths:**
  - Debounce: `$clog2(STABLE_CYCLES+1)`.
  - Hold: `$clog2(HOLD_CYCLES+1)`.
  - Neither counter wraps.

## Timing
- **Reset values:** all outputs 0; all counters 0. Reset is effective immediately, regardless of `clk`.
- **Reset mid-operation:** discards in-progress debounce and hold counts and pending flags. After release, a pin already held pressed is re-debounced and generates a fresh `pressed` event.
- **Pin to `state` latency:** a clean pin change is visible on `state` 2 + `STABLE_CYCLES` edges after it is sampled.
- **Flags:** `pressed`/`released` assert on the same edge that `state` changes.
- **Hold:** `held` asserts `HOLD_CYCLES` edges after `state` rises.
- **irq:** asserts one edge after the flag that causes it.
- **Clear:** takes effect on the edge sampling `clr_en`. `irq` drops one edge later.
- **Channels:** fully independent; simultaneous events on different channels all register.

## Structure
- **Package `niski_io_pkg`:** holds
  - default parameter constants `BTN_CHANNELS_DEFAULT` and `BTN_STABLE_CYCLES_DEFAULT`;
  - a `btn_events_t` struct holding the `pressed`/`released`/`held` vectors, shared with the GPIO register block.
- **Sub-module `btn_debounce_ch`:** one channel, comprising the synchroniser, debounce counter, hold counter and the three flags. It is instantiated `CHANNELS` times in a generate loop. The top level adds polarity handling and `irq`.

## Test plan
Every scenario uses `CHANNELS`=5, `STABLE_CYCLES`=4, `HOLD_CYCLES`=16, `ACTIVE_LOW`=1, `irq_mask`=5'b11111.

1. **Clean press:** assert `rst_n`=0 then release; drive pin 3 to 0. Required: `state[3]`=1 and `pressed[3]`=1 exactly 6 edges later; `irq`=1 at edge 7; other channels stay 0.
2. **Bounce rejection:** toggle pin 0 low/high every 2 cycles for 20 cycles, then hold high. Required: `state[0]` never asserts and `pressed[0]` stays 0.
3. **Long hold:** hold pin 1 low for 30 cycles after debounce. Required: `held[1]` sets 16 edges after `state[1]` rises, and sets only once. On release, `released[1]`=1 6 edges after the pin goes high.
4. **Clear collision:** pulse `clr_en` with `clr_mask`=5'b00100 on the same edge that `pressed[2]` would set. Required: `pressed[2]` remains 1. A clear on the next cycle sets it to 0, and `irq` falls one edge later.
5. **Masking and concurrency:** press channels 0 and 4 on the same cycle with `irq_mask`=5'b00001. Required: both `pressed` bits set on the same edge; `irq`=1. Clearing channel 0 drops `irq` even though `pressed[4]`=1.
6. **Async reset mid-debounce:** pin 2 has been low for 3 cycles when `rst_n` pulses low mid-cycle. Required: all outputs become 0 immediately. With the pin still low, `state[2]` rises 6 edges after `rst_n` releases.
